// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel clock-enable generator for the MSP430 peripheral bus.
// Each channel divides MCLK or the synchronised LFXT rising edge by DIV+1.
// Each channel emits a one-cycle enable tick on clk_en.
module clk_en_gen #(
   parameter int         NCH        = 4,
   parameter int         DIV_W      = 8,
   parameter logic [7:0] BASE_WADDR = 8'h30
) (
   input  logic             mclk,
   input  logic             puc,
   input  logic [7:0]       per_addr,
   input  logic [15:0]      per_din,
   input  logic             per_en,
   input  logic [1:0]       per_wen,
   input  logic             lfxt_clk,
   input  logic             oscoff,
   output logic [15:0]      per_dout,
   output logic [NCH-1:0]   clk_en
);

   // Only DIV, SEL (bit 14) and EN (bit 15) exist; every other bit is tied to zero.
   localparam logic [15:0] CTL_MASK = 16'hC000 | {{(16-DIV_W){1'b0}}, {DIV_W{1'b1}}};

   logic [2:0]  r_lfxt_s;
   logic        w_lfxt_tick;
   logic [15:0] w_rd_data [NCH];

   // Bring the asynchronous LFXT clock into the mclk domain.
   always_ff @(posedge mclk) begin
      if (puc) begin
         r_lfxt_s <= 3'b000;
      end else begin
         r_lfxt_s <= {r_lfxt_s[1:0], lfxt_clk};
      end
   end

   // One shared tick per LFXT rising edge, muted while the oscillator is off.
   assign w_lfxt_tick = r_lfxt_s[1] & ~r_lfxt_s[2] & ~oscoff;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         localparam logic [7:0] CH_ADDR = BASE_WADDR + 8'(gi);

         logic [15:0]      r_ctl;
         logic [DIV_W-1:0] r_cnt;
         logic             w_sel;
         logic             w_wr_lo;
         logic             w_wr_hi;
         logic             w_wr;
         logic             w_src;
         logic             w_hit;
         logic [15:0]      w_ctl_next;

         assign w_sel      = per_en & (per_addr == CH_ADDR);
         assign w_wr_lo    = w_sel & per_wen[0];
         assign w_wr_hi    = w_sel & per_wen[1];
         assign w_wr       = w_wr_lo | w_wr_hi;
         assign w_ctl_next = {w_wr_hi ? per_din[15:8] : r_ctl[15:8],
                              w_wr_lo ? per_din[7:0]  : r_ctl[7:0]} & CTL_MASK;

         // Control register with independent byte lanes.
         always_ff @(posedge mclk) begin
            if (puc) begin
               r_ctl <= 16'h0000;
            end else if (w_wr) begin
               r_ctl <= w_ctl_next;
            end
         end

         assign w_src = r_ctl[14] ? w_lfxt_tick : 1'b1;
         assign w_hit = (r_cnt == r_ctl[DIV_W-1:0]);

         // Divider phase counter; a register write restarts the phase.
         always_ff @(posedge mclk) begin
            if (puc || w_wr || !r_ctl[15]) begin
               r_cnt <= '0;
            end else if (w_src) begin
               r_cnt <= w_hit ? '0 : r_cnt + DIV_W'(1);
            end
         end

         // The tick uses the current registers, so a coincident write cannot swallow it.
         assign clk_en[gi]    = r_ctl[15] & w_src & w_hit;
         assign w_rd_data[gi] = (w_sel & ~|per_wen) ? r_ctl : 16'h0000;
      end
   endgenerate

   // Read mux: at most one channel is selected, so an OR-reduction suffices.
   always_comb begin
      per_dout = 16'h0000;
      for (int i = 0; i < NCH; i++) begin
         per_dout = per_dout | w_rd_data[i];
      end
   end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed self-checking bench for clk_en_gen (NCH=4, DIV_W=8, base 8'h30).
module tb_clk_en_gen;

   logic        mclk;
   logic        puc;
   logic [7:0]  per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_wen;
   logic        lfxt_clk;
   logic        oscoff;
   logic [15:0] per_dout;
   logic [3:0]  clk_en;

   int checks = 0;
   int errors = 0;

   clk_en_gen #(
      .NCH        (4),
      .DIV_W      (8),
      .BASE_WADDR (8'h30)
   ) dut (
      .mclk     (mclk),
      .puc      (puc),
      .per_addr (per_addr),
      .per_din  (per_din),
      .per_en   (per_en),
      .per_wen  (per_wen),
      .lfxt_clk (lfxt_clk),
      .oscoff   (oscoff),
      .per_dout (per_dout),
      .clk_en   (clk_en)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end else begin
         $display("ok   %s: %h", tag, act);
      end
   endtask

   task automatic step;
      @(negedge mclk);
   endtask

   task automatic wr_begin(input logic [7:0] a, input logic [15:0] d, input logic [1:0] w);
      per_en   = 1'b1;
      per_addr = a;
      per_din  = d;
      per_wen  = w;
   endtask

   task automatic wr_end;
      @(negedge mclk);
      per_en  = 1'b0;
      per_wen = 2'b00;
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] w);
      wr_begin(a, d, w);
      wr_end();
   endtask

   task automatic rd(input string tag, input logic [7:0] a, input logic [15:0] exp);
      per_en   = 1'b1;
      per_wen  = 2'b00;
      per_addr = a;
      #1;
      chk(tag, per_dout, exp);
      per_en   = 1'b0;
   endtask

   // One LFXT period of 20 mclk cycles; the tick must land 2..3 samples after the rise.
   task automatic lfxt_rise(input string tag, input logic exp_pulse);
      int in_win;
      int out_win;
      in_win   = 0;
      out_win  = 0;
      lfxt_clk = 1'b1;
      for (int s = 1; s <= 20; s++) begin
         step();
         if (s == 2 || s == 3) in_win += int'(clk_en[1]);
         else                  out_win += int'(clk_en[1]);
         if (s == 10) lfxt_clk = 1'b0;
      end
      chk({tag, "_win"}, 16'(in_win), 16'(exp_pulse));
      chk({tag, "_out"}, 16'(out_win), 16'h0000);
   endtask

   initial begin
      int acc;
      puc      = 1'b1;
      per_addr = 8'h00;
      per_din  = 16'h0000;
      per_en   = 1'b0;
      per_wen  = 2'b00;
      lfxt_clk = 1'b0;
      oscoff   = 1'b0;

      // Reset
      repeat (3) step();
      chk("rst_clk_en", 16'(clk_en), 16'h0000);
      rd("rst_ctl0", 8'h30, 16'h0000);
      rd("rst_ctl1", 8'h31, 16'h0000);
      rd("rst_ctl2", 8'h32, 16'h0000);
      rd("rst_ctl3", 8'h33, 16'h0000);
      puc = 1'b0;
      step();
      chk("post_rst_clk_en", 16'(clk_en), 16'h0000);

      // DIV=3 on MCLK: pulses every 4th cycle, one cycle wide
      wr(8'h30, 16'h8003, 2'b11);
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("div3_c%0d", i), 16'(clk_en), (i % 4 == 3) ? 16'h0001 : 16'h0000);
         step();
      end
      wr(8'h30, 16'h0000, 2'b11);

      // Byte lane writes and masking
      wr(8'h30, 16'h00FF, 2'b01);
      rd("byte_lo", 8'h30, 16'h00FF);
      wr(8'h30, 16'hFF00, 2'b10);
      rd("byte_hi", 8'h30, 16'hC0FF);
      rd("oor_34", 8'h34, 16'h0000);
      rd("oor_2f", 8'h2F, 16'h0000);
      wr(8'h30, 16'h0000, 2'b11);

      // Mid-count rewrite restarts the phase
      wr(8'h30, 16'h8003, 2'b11);
      step();
      step();
      chk("pre_restart", 16'(clk_en), 16'h0000);
      wr(8'h30, 16'h8003, 2'b11);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("restart_c%0d", i), 16'(clk_en), 16'h0000);
         step();
      end
      chk("restart_hit", 16'(clk_en), 16'h0001);

      // Write coinciding with a hit keeps that pulse
      wr_begin(8'h30, 16'h8002, 2'b11);
      #1;
      chk("wr_at_hit", 16'(clk_en), 16'h0001);
      chk("wr_dout_zero", per_dout, 16'h0000);
      wr_end();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("div2_c%0d", i), 16'(clk_en), (i == 2) ? 16'h0001 : 16'h0000);
         step();
      end
      wr(8'h30, 16'h0000, 2'b11);

      // Reset in mid-count
      wr(8'h30, 16'h8005, 2'b11);
      wr(8'h32, 16'h8000, 2'b11);
      chk("div0_every", 16'(clk_en), 16'h0004);
      step();
      step();
      puc = 1'b1;
      step();
      chk("puc_clk_en", 16'(clk_en), 16'h0000);
      rd("puc_ctl0", 8'h30, 16'h0000);
      rd("puc_ctl2", 8'h32, 16'h0000);
      puc = 1'b0;
      acc = 0;
      repeat (12) begin
         step();
         acc += int'(|clk_en);
      end
      chk("post_puc_quiet", 16'(acc), 16'h0000);

      // LFXT source, DIV=1: every second rise
      wr(8'h31, 16'hC001, 2'b11);
      rd("ctl1_rb", 8'h31, 16'hC001);
      lfxt_rise("lf_r1", 1'b0);
      lfxt_rise("lf_r2", 1'b1);
      lfxt_rise("lf_r3", 1'b0);
      lfxt_rise("lf_r4", 1'b1);
      oscoff = 1'b1;
      lfxt_rise("off_r1", 1'b0);
      lfxt_rise("off_r2", 1'b0);
      lfxt_rise("off_r3", 1'b0);
      oscoff = 1'b0;
      lfxt_rise("on_r1", 1'b0);
      lfxt_rise("on_r2", 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
